// File: rtl/fpu_fused_seq.sv
// fpu_fused_seq: queued FP op sequencer in front of a single-issue core.
// FMA-family ops run as a MUL pass followed by an ADD/SUB pass with c.
module fpu_fused_seq #(
  parameter int FLEN   = 32,
  parameter int QDEPTH = 4,
  parameter int TAGW   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [4:0]                   in_op,
  input  logic [2:0]                   in_rm,
  input  logic [FLEN-1:0]              in_a,
  input  logic [FLEN-1:0]              in_b,
  input  logic [FLEN-1:0]              in_c,
  input  logic [TAGW-1:0]              in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [FLEN-1:0]              out_y,
  output logic [TAGW-1:0]              out_tag,
  output logic [4:0]                   out_flags,
  output logic                         core_valid,
  input  logic                         core_ready,
  output logic [4:0]                   core_op,
  output logic [2:0]                   core_rm,
  output logic [FLEN-1:0]              core_a,
  output logic [FLEN-1:0]              core_b,
  input  logic                         core_res_valid,
  output logic                         core_res_ready,
  input  logic [FLEN-1:0]              core_y,
  input  logic [4:0]                   core_flags,
  output logic [$clog2(QDEPTH+1)-1:0]  count,
  output logic                         busy
);
  localparam int CW = $clog2(QDEPTH+1);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  localparam logic [4:0] OP_NOP   = 5'd0;
  localparam logic [4:0] OP_ADD   = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_MUL   = 5'd3;
  localparam logic [4:0] OP_MADD  = 5'd8;
  localparam logic [4:0] OP_MSUB  = 5'd9;
  localparam logic [4:0] OP_NMSUB = 5'd10;
  localparam logic [4:0] OP_NMADD = 5'd11;

  typedef struct packed {
    logic [4:0]      op;
    logic [2:0]      rm;
    logic [FLEN-1:0] a;
    logic [FLEN-1:0] b;
    logic [FLEN-1:0] c;
    logic [TAGW-1:0] tag;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE1, S_WAIT1, S_ISSUE2, S_WAIT2, S_OUT
  } state_t;

  state_t          state_q, state_d;
  cmd_t            mem_q [QDEPTH];
  cmd_t            in_cmd, head;
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [4:0]      op_q, op_d;
  logic [2:0]      rm_q, rm_d;
  logic [FLEN-1:0] c_q, c_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic [4:0]      cop_q, cop_d;
  logic [FLEN-1:0] ca_q, ca_d;
  logic [FLEN-1:0] cb_q, cb_d;
  logic [FLEN-1:0] y_q, y_d;
  logic [4:0]      fl_q, fl_d;
  logic            full, empty, push, pop, neg;

  function automatic logic fused(input logic [4:0] op);
    return op inside {OP_MADD, OP_MSUB, OP_NMSUB, OP_NMADD};
  endfunction

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign in_cmd = '{op: in_op, rm: in_rm, a: in_a,
                    b: in_b, c: in_c, tag: in_tag};
  assign head   = mem_q[rptr_q];
  assign full   = (cnt_q == CW'(QDEPTH));
  assign empty  = (cnt_q == '0);
  assign push   = in_valid && !full && (in_op != OP_NOP);
  assign pop    = (state_q == S_IDLE) && !empty;
  assign neg    = (op_q == OP_NMADD) || (op_q == OP_NMSUB);

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rm_d    = rm_q;
    c_d     = c_q;
    tag_d   = tag_q;
    cop_d   = cop_q;
    ca_d    = ca_q;
    cb_d    = cb_q;
    y_d     = y_q;
    fl_d    = fl_q;
    case (state_q)
      S_IDLE: if (!empty) begin
        op_d    = head.op;
        rm_d    = head.rm;
        c_d     = head.c;
        tag_d   = head.tag;
        cop_d   = fused(head.op) ? OP_MUL : head.op;
        ca_d    = head.a;
        cb_d    = head.b;
        state_d = S_ISSUE1;
      end
      S_ISSUE1: if (core_ready) state_d = S_WAIT1;
      S_WAIT1: if (core_res_valid) begin
        fl_d = core_flags;
        if (fused(op_q)) begin
          // product sign flipped here for the negated forms
          ca_d = {core_y[FLEN-1] ^ neg, core_y[FLEN-2:0]};
          cb_d = c_q;
          unique case (1'b1)
            op_q == OP_MSUB,
            op_q == OP_NMADD: cop_d = OP_SUB;
            default:          cop_d = OP_ADD;
          endcase
          state_d = S_ISSUE2;
        end else begin
          y_d     = core_y;
          state_d = S_OUT;
        end
      end
      S_ISSUE2: if (core_ready) state_d = S_WAIT2;
      S_WAIT2: if (core_res_valid) begin
        y_d     = core_y;
        fl_d    = fl_q | core_flags;
        state_d = S_OUT;
      end
      S_OUT: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (push) wptr_d = nxt(wptr_q);
    if (pop)  rptr_d = nxt(rptr_q);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    if (flush) begin
      state_d = S_IDLE;
      wptr_d  = '0;
      rptr_d  = '0;
      cnt_d   = '0;
      fl_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      rm_q    <= '0;
      c_q     <= '0;
      tag_q   <= '0;
      cop_q   <= '0;
      ca_q    <= '0;
      cb_q    <= '0;
      y_q     <= '0;
      fl_q    <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rm_q    <= rm_d;
      c_q     <= c_d;
      tag_q   <= tag_d;
      cop_q   <= cop_d;
      ca_q    <= ca_d;
      cb_q    <= cb_d;
      y_q     <= y_d;
      fl_q    <= fl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wptr_q] <= in_cmd;
  end

  assign in_ready       = !full;
  assign count          = cnt_q;
  assign busy           = !empty || (state_q != S_IDLE);
  assign core_valid     = (state_q == S_ISSUE1) || (state_q == S_ISSUE2);
  assign core_res_ready = (state_q == S_WAIT1) || (state_q == S_WAIT2);
  assign core_op        = cop_q;
  assign core_rm        = rm_q;
  assign core_a         = ca_q;
  assign core_b         = cb_q;
  assign out_valid      = (state_q == S_OUT);
  assign out_y          = y_q;
  assign out_tag        = tag_q;
  assign out_flags      = fl_q;
endmodule

// File: tb/tb_fpu_fused_seq.sv
// tb_fpu_fused_seq: directed vectors against a 1-cycle table-driven core
// model with hand-computed single-precision results.
module tb_fpu_fused_seq;
  localparam logic [4:0] NOP   = 5'd0;
  localparam logic [4:0] ADD   = 5'd1;
  localparam logic [4:0] SUB   = 5'd2;
  localparam logic [4:0] MUL   = 5'd3;
  localparam logic [4:0] MADD  = 5'd8;
  localparam logic [4:0] MSUB  = 5'd9;
  localparam logic [4:0] NMSUB = 5'd10;
  localparam logic [4:0] NMADD = 5'd11;

  localparam logic [31:0] F1  = 32'h3F800000;
  localparam logic [31:0] F2  = 32'h40000000;
  localparam logic [31:0] F3  = 32'h40400000;
  localparam logic [31:0] F6  = 32'h40C00000;
  localparam logic [31:0] FN6 = 32'hC0C00000;

  logic        clk = 0, reset = 1, flush = 0;
  logic        in_valid = 0, in_ready;
  logic [4:0]  in_op = 0;
  logic [2:0]  in_rm = 0;
  logic [31:0] in_a = 0, in_b = 0, in_c = 0;
  logic [3:0]  in_tag = 0;
  logic        out_valid, out_ready = 1;
  logic [31:0] out_y;
  logic [3:0]  out_tag;
  logic [4:0]  out_flags;
  logic        core_valid, core_ready, core_res_valid, core_res_ready;
  logic [4:0]  core_op, core_flags;
  logic [2:0]  core_rm;
  logic [31:0] core_a, core_b, core_y;
  logic [2:0]  count;
  logic        busy;

  fpu_fused_seq #(.FLEN(32), .QDEPTH(4), .TAGW(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rm(in_rm), .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_tag(out_tag), .out_flags(out_flags),
    .core_valid(core_valid), .core_ready(core_ready),
    .core_op(core_op), .core_rm(core_rm), .core_a(core_a),
    .core_b(core_b), .core_res_valid(core_res_valid),
    .core_res_ready(core_res_ready), .core_y(core_y),
    .core_flags(core_flags), .count(count), .busy(busy)
  );

  always #5 clk = ~clk;

  // core model: accepts when cr=1, answers one cycle later
  logic        cr = 1, pend;
  logic [31:0] res_y;
  logic [4:0]  res_fl;
  logic [4:0]  fl_first = 0, fl_second = 0;
  int          acc_n, base_n = 0;
  logic [4:0]  log_op [64];
  logic [2:0]  log_rm [64];
  logic [31:0] log_a [64], log_b [64];

  function automatic logic [31:0] fp_model(input logic [4:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    case ({op, a, b})
      {MUL, F2, F3}:  return F6;
      {ADD, F2, F3}:  return 32'h40A00000;
      {SUB, F2, F3}:  return 32'hBF800000;
      {ADD, F6, F1}:  return 32'h40E00000;
      {SUB, F6, F1}:  return 32'h40A00000;
      {SUB, FN6, F1}: return 32'hC0E00000;
      {ADD, FN6, F1}: return 32'hC0A00000;
      {ADD, F1, F1}:  return F2;
      default:        return 32'hDEADBEEF;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pend  <= 0;
      acc_n <= 0;
      res_y <= 0;
      res_fl <= 0;
    end else if (flush) begin
      pend <= 0;
    end else if (core_valid && cr) begin
      pend   <= 1;
      res_y  <= fp_model(core_op, core_a, core_b);
      res_fl <= (acc_n == base_n) ? fl_first : fl_second;
      log_op[acc_n[5:0]] <= core_op;
      log_rm[acc_n[5:0]] <= core_rm;
      log_a[acc_n[5:0]]  <= core_a;
      log_b[acc_n[5:0]]  <= core_b;
      acc_n <= acc_n + 1;
    end else if (pend && core_res_ready) begin
      pend <= 0;
    end
  end

  assign core_ready     = cr;
  assign core_res_valid = pend;
  assign core_y         = res_y;
  assign core_flags     = res_fl;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [4:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] c,
                      input logic [3:0] tg);
    in_valid = 1; in_op = op; in_a = a; in_b = b; in_c = c;
    in_tag = tg;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic get_res(output logic [31:0] y, output logic [3:0] tg,
                         output logic [4:0] fl);
    int k = 0;
    while (!out_valid && k < 200) begin
      @(posedge clk); #1; k++;
    end
    chk("res_timeout", 64'(out_valid), 64'd1);
    y = out_y; tg = out_tag; fl = out_flags;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b, c;
    logic [3:0]  tag;
    logic [4:0]  f1, f2;
    logic [31:0] y;
    logic [4:0]  fl;
    int          lat;
    logic [4:0]  op1, op2;
    logic [31:0] a2;
  } vec_t;

  vec_t vt [8];

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] y;
    logic [3:0]  tg;
    logic [4:0]  fl;
    logic [31:0] y0;
    logic [3:0]  t0;
    logic        stable, saw;
    int          n;

    vt[0] = '{ADD,   F2, F3, F1, 4'd1, 5'd0, 5'd0, 32'h40A00000,
               5'd0, 4, ADD, ADD, 32'h0};
    vt[1] = '{SUB,   F2, F3, F1, 4'd2, 5'd1, 5'd0, 32'hBF800000,
               5'd1, 4, SUB, SUB, 32'h0};
    vt[2] = '{MUL,   F2, F3, F1, 4'd3, 5'd0, 5'd0, F6,
               5'd0, 4, MUL, MUL, 32'h0};
    vt[3] = '{MADD,  F2, F3, F1, 4'd5, 5'd0, 5'd0, 32'h40E00000,
               5'd0, 6, MUL, ADD, F6};
    vt[4] = '{MSUB,  F2, F3, F1, 4'd6, 5'd0, 5'd0, 32'h40A00000,
               5'd0, 6, MUL, SUB, F6};
    vt[5] = '{NMADD, F2, F3, F1, 4'd7, 5'd0, 5'd0, 32'hC0E00000,
               5'd0, 6, MUL, SUB, FN6};
    vt[6] = '{NMSUB, F2, F3, F1, 4'd8, 5'd0, 5'd0, 32'hC0A00000,
               5'd0, 6, MUL, ADD, FN6};
    vt[7] = '{MADD,  F2, F3, F1, 4'd9, 5'b00100, 5'b00001,
               32'h40E00000, 5'b00101, 6, MUL, ADD, F6};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_core_valid", 64'(core_valid), 64'd0);
    chk("rst_res_ready", 64'(core_res_ready), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_y", 64'(out_y), 64'd0);
    reset = 0;
    @(posedge clk); #1;

    push(NOP, F2, F3, F1, 4'd0);
    chk("nop_count", 64'(count), 64'd0);
    chk("nop_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 8; i++) begin
      base_n = acc_n;
      fl_first = vt[i].f1;
      fl_second = vt[i].f2;
      in_rm = 3'(i);
      push(vt[i].op, vt[i].a, vt[i].b, vt[i].c, vt[i].tag);
      n = 1;
      while (!out_valid && n < 30) begin
        @(posedge clk); #1; n++;
      end
      chk("latency", 64'(n), 64'(vt[i].lat));
      chk("out_y", 64'(out_y), 64'(vt[i].y));
      chk("out_tag", 64'(out_tag), 64'(vt[i].tag));
      chk("out_flags", 64'(out_flags), 64'(vt[i].fl));
      chk("pass1_op", 64'(log_op[base_n[5:0]]), 64'(vt[i].op1));
      chk("pass1_rm", 64'(log_rm[base_n[5:0]]), 64'(i % 8));
      if (vt[i].lat == 6) begin
        chk("pass2_op", 64'(log_op[(base_n+1) % 64]), 64'(vt[i].op2));
        chk("pass2_a", 64'(log_a[(base_n+1) % 64]), 64'(vt[i].a2));
        chk("pass2_b", 64'(log_b[(base_n+1) % 64]), 64'(vt[i].c));
        chk("pass2_rm", 64'(log_rm[(base_n+1) % 64]), 64'(i % 8));
      end
      @(posedge clk); #1;
    end
    in_rm = 0;
    fl_first = 0;
    fl_second = 0;

    // back-to-back fused ops, results in order
    base_n = acc_n;
    push(MSUB,  F2, F3, F1, 4'd1);
    push(NMADD, F2, F3, F1, 4'd2);
    push(NMSUB, F2, F3, F1, 4'd3);
    get_res(y, tg, fl);
    chk("b2b_y0", 64'(y), 64'h40A00000);
    chk("b2b_t0", 64'(tg), 64'd1);
    get_res(y, tg, fl);
    chk("b2b_y1", 64'(y), 64'hC0E00000);
    chk("b2b_t1", 64'(tg), 64'd2);
    get_res(y, tg, fl);
    chk("b2b_y2", 64'(y), 64'hC0A00000);
    chk("b2b_t2", 64'(tg), 64'd3);
    chk("b2b_a2_0", 64'(log_a[(base_n+1) % 64]), 64'(F6));
    chk("b2b_a2_1", 64'(log_a[(base_n+3) % 64]), 64'(FN6));
    chk("b2b_a2_2", 64'(log_a[(base_n+5) % 64]), 64'(FN6));

    // fill the queue behind a stalled core
    cr = 0;
    for (int i = 1; i <= 5; i++) begin
      chk("fill_in_ready", 64'(in_ready), 64'd1);
      push(ADD, F2, F3, F1, 4'(i));
    end
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_count", 64'(count), 64'd4);
    cr = 1;
    for (int i = 1; i <= 5; i++) begin
      get_res(y, tg, fl);
      chk("drain_tag", 64'(tg), 64'(i));
      chk("drain_y", 64'(y), 64'h40A00000);
    end

    // output back-pressure
    out_ready = 0;
    push(ADD, F2, F3, F1, 4'hB);
    push(ADD, F1, F1, F1, 4'hC);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("hold_valid", 64'(out_valid), 64'd1);
    chk("hold_y", 64'(out_y), 64'h40A00000);
    chk("hold_tag", 64'(out_tag), 64'hB);
    chk("hold_count", 64'(count), 64'd1);
    y0 = out_y;
    t0 = out_tag;
    stable = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!out_valid || out_y !== y0 || out_tag !== t0 ||
          count !== 3'd1 || core_valid)
        stable = 0;
    end
    chk("hold_stable", 64'(stable), 64'd1);
    out_ready = 1;
    @(posedge clk); #1;
    get_res(y, tg, fl);
    chk("hold_next_y", 64'(y), 64'h40000000);
    chk("hold_next_tag", 64'(tg), 64'hC);

    // flush in WAIT2 while the core result is valid
    base_n = acc_n;
    push(MADD, F2, F3, F1, 4'h4);
    n = 0;
    while (!(acc_n == base_n + 2 && core_res_valid) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("flush_reach_wait2", 64'(core_res_valid && core_res_ready),
        64'd1);
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_busy", 64'(busy), 64'd0);
    saw = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) saw = 1;
      @(posedge clk); #1;
    end
    chk("flush_no_result", 64'(saw), 64'd0);
    push(ADD, F1, F1, F1, 4'hA);
    get_res(y, tg, fl);
    chk("post_flush_y", 64'(y), 64'h40000000);
    chk("post_flush_tag", 64'(tg), 64'hA);
    chk("post_flush_flags", 64'(fl), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
